// File: rtl/dut_top.sv
// Request FIFO feeding a fixed-latency processing engine; each queued item is
// returned unmodified on a one-cycle response strobe after COUNT busy cycles.
module dut_top #(
  parameter int DATA_SIZE = 16,
  parameter     CNFG      = "READY_VALID",
  parameter int COUNT     = 3,
  parameter int DEPTH     = 3
) (
  input  logic                 clk_i,
  input  logic                 clrst_if,
  input  logic                 req_valid_i,
  input  logic [DATA_SIZE-1:0] req_data_i,
  output logic                 req_ready_o,
  output logic                 resp_valid_o,
  output logic [DATA_SIZE-1:0] resp_data_o
);

  if (CNFG != "READY_VALID" && CNFG != "VALID_READY") begin : g_bad_cnfg
    $error("dut_top: CNFG must be \"READY_VALID\" or \"VALID_READY\"");
  end
  if (COUNT < 1) begin : g_bad_count
    $error("dut_top: COUNT must be >= 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("dut_top: DEPTH must be >= 1");
  end

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int KW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        occ;
  logic                 full, empty, push, pop, fire;
  state_t               state, state_nx;
  logic [KW-1:0]        cnt;
  logic [DATA_SIZE-1:0] hold;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (occ == CW'(DEPTH));
  assign empty = (occ == '0);

  // Ready is forced low during reset; full uses current occupancy, ignoring a same-cycle pop.
  if (CNFG == "READY_VALID") begin : g_rv
    assign req_ready_o = !clrst_if && !full;
  end else begin : g_vr
    assign req_ready_o = !clrst_if && !full && req_valid_i;
  end

  assign push = req_valid_i && req_ready_o;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= req_data_i;
  end

  always_ff @(posedge clk_i or posedge clrst_if) begin
    if (clrst_if) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge clrst_if) begin
    if (clrst_if) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    fire     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt == KW'(COUNT - 1)) begin
          fire     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge clrst_if) begin
    if (clrst_if) begin
      cnt          <= '0;
      hold         <= '0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
    end else begin
      resp_valid_o <= fire;
      if (fire) resp_data_o <= hold;
      if (pop) begin
        hold <= mem[rd_ptr];
        cnt  <= '0;
      end else if (fire) begin
        cnt <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dut_top.sv
// Randomised and directed bench for dut_top in both handshake modes, checked
// against a timeline model derived from push edges and the engine latency.
module tb_dut_top;

  localparam int DW  = 16;
  localparam int CNT = 3;
  localparam int DEP = 3;

  logic          clk = 1'b0;
  logic          clrst_if = 1'b0;
  logic          req_valid_i = 1'b0;
  logic [DW-1:0] req_data_i = '0;
  logic          rdy_rv, val_rv, rdy_vr, val_vr;
  logic [DW-1:0] dat_rv, dat_vr;

  dut_top #(.DATA_SIZE(DW), .CNFG("READY_VALID"), .COUNT(CNT), .DEPTH(DEP)) u_dut (
    .clk_i(clk), .clrst_if(clrst_if), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(rdy_rv), .resp_valid_o(val_rv), .resp_data_o(dat_rv)
  );

  dut_top #(.DATA_SIZE(DW), .CNFG("VALID_READY"), .COUNT(CNT), .DEPTH(DEP)) u_dut_vr (
    .clk_i(clk), .clrst_if(clrst_if), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(rdy_vr), .resp_valid_o(val_vr), .resp_data_o(dat_vr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int resp_seen = 0;
  int last_resp_cyc = 0;
  int resp_cyc_q[$];

  // Model: each item's pop and response edges follow from its push edge and
  // from when the in-order engine frees up after the previous response.
  int            push_e[$], pop_e[$], resp_e[$];
  logic [DW-1:0] dat_q[$];
  int            last_resp_e = -1000;
  logic [DW-1:0] last_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int occ_before(input int e);
    int n = 0;
    foreach (push_e[i]) if (push_e[i] < e && pop_e[i] >= e) n++;
    return n;
  endfunction

  function automatic void model_forget();
    push_e.delete(); pop_e.delete(); resp_e.delete(); dat_q.delete();
    resp_cyc_q.delete();
    resp_seen = 0;
  endfunction

  function automatic void model_push(input int p, input logic [DW-1:0] d);
    int pp;
    pp = (p + 1 > last_resp_e + 1) ? p + 1 : last_resp_e + 1;
    push_e.push_back(p);
    pop_e.push_back(pp);
    resp_e.push_back(pp + CNT);
    dat_q.push_back(d);
    last_resp_e = pp + CNT;
  endfunction

  function automatic bit pending();
    foreach (resp_e[i]) if (resp_e[i] > cyc) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input logic v, input logic [DW-1:0] d, output bit pushed);
    bit            full_e, exp_v;
    logic [DW-1:0] exp_d;
    req_valid_i = v;
    req_data_i  = d;
    #1;
    full_e = (occ_before(cyc + 1) >= DEP);
    check("ready_rv", 32'(rdy_rv), 32'(!clrst_if && !full_e));
    check("ready_vr", 32'(rdy_vr), 32'(!clrst_if && v && !full_e));
    pushed = v && !clrst_if && !full_e;
    if (pushed) model_push(cyc + 1, d);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    exp_v = 1'b0;
    exp_d = last_data;
    if (!clrst_if) foreach (resp_e[i]) if (resp_e[i] == cyc) begin
      exp_v = 1'b1;
      exp_d = dat_q[i];
    end
    last_data = exp_d;
    check("resp_valid_rv", 32'(val_rv), 32'(exp_v));
    check("resp_data_rv",  32'(dat_rv), 32'(exp_d));
    check("resp_valid_vr", 32'(val_vr), 32'(exp_v));
    check("resp_data_vr",  32'(dat_vr), 32'(exp_d));
    if (val_rv === 1'b1) begin
      resp_seen++;
      last_resp_cyc = cyc;
      resp_cyc_q.push_back(cyc);
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit p = 1'b0;
    for (int k = 0; k < 50 && !p; k++) step(1'b1, d, p);
    check("send_accepted", 32'(p), 32'd1);
  endtask

  task automatic idle(input int n);
    bit p;
    for (int k = 0; k < n; k++) step(1'b0, DW'($urandom), p);
  endtask

  task automatic drain(input string tag);
    bit p;
    for (int k = 0; k < 200 && pending(); k++) step(1'b0, '0, p);
    check(tag, 32'(resp_seen), 32'(dat_q.size()));
    idle(2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int start, push_cyc;
    bit p;
    #1 clrst_if = 1'b1;
    #1;
    check("rst_ready_rv", 32'(rdy_rv), 32'd0);
    check("rst_resp_valid", 32'(val_rv), 32'd0);
    check("rst_resp_data", 32'(dat_rv), 32'd0);
    idle(3);
    clrst_if = 1'b0;
    idle(2);

    // single item
    model_forget();
    send(16'd10);
    push_cyc = cyc;
    drain("single_count");
    check("single_latency", 32'(last_resp_cyc - push_cyc), 32'(CNT + 1));

    // back-to-back fill
    model_forget();
    send(16'd20); send(16'd21); send(16'd22);
    drain("fill_count");
    for (int i = 1; i < resp_cyc_q.size(); i++)
      check("fill_spacing", 32'(resp_cyc_q[i] - resp_cyc_q[i-1]), 32'(CNT + 1));

    // overfill: ready must fall once three items wait behind the engine
    model_forget();
    for (int i = 30; i <= 33; i++) send(DW'(i));
    drain("overfill_count");

    // stream
    model_forget();
    start = cyc;
    for (int i = 40; i <= 45; i++) send(DW'(i));
    drain("stream_count");
    check("stream_within_200", 32'(last_resp_cyc - start <= 200), 32'd1);

    // random traffic
    model_forget();
    for (int k = 0; k < 300; k++) step($urandom_range(0, 3) != 0, DW'($urandom), p);
    drain("random_count");

    // reset with one item in flight and two queued
    model_forget();
    send(16'd50); send(16'd51); send(16'd52);
    clrst_if = 1'b1;
    model_forget();
    last_resp_e = -1000;
    last_data   = '0;
    #1;
    check("midrst_resp_valid", 32'(val_rv), 32'd0);
    check("midrst_resp_data", 32'(dat_rv), 32'd0);
    check("midrst_ready", 32'(rdy_rv), 32'd0);
    idle(3);
    clrst_if = 1'b0;
    idle(20);
    check("midrst_no_resp", 32'(resp_seen), 32'd0);
    send(16'd60);
    drain("post_reset_count");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
